// File: rtl/bram_port_v2.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_v2
// Brief    : Single-port byte-addressed BRAM with byte write enables, a
//            post-reset clear sweep and misaligned/out-of-range error flags.
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_v2 #(
    parameter int                DATA_W         = 32,
    parameter int                MEM_DEPTH      = 1024,
    parameter int                ADDR_W         = 32,
    parameter int                READ_LATENCY   = 1,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE     = '0
) (
    input  logic                  clkb,
    input  logic                  rstb_n,
    input  logic                  enb,
    input  logic [DATA_W/8-1:0]   web,
    input  logic [ADDR_W-1:0]     addrb,
    input  logic [DATA_W-1:0]     dinb,
    output logic [DATA_W-1:0]     doutb,
    output logic                  rvalid,
    output logic                  err,
    output logic                  rstb_busy
);

    localparam int c_nbytes = DATA_W / 8;
    localparam int c_ofs    = (c_nbytes > 1) ? $clog2(c_nbytes) : 0;
    localparam int c_ptr_w  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int c_idx_w  = ADDR_W - c_ofs;
    localparam int c_cmp_w  = (c_idx_w > 32) ? c_idx_w : 32;

    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(MEM_DEPTH - 1);
    localparam logic [c_cmp_w-1:0] c_depth = c_cmp_w'(MEM_DEPTH);

    localparam logic [1:0] c_st_rst   = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_idle  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_ptr_w-1:0]  r_ptr;
    logic [c_ptr_w-1:0]  w_ptr_nxt;

    logic [c_idx_w-1:0]  w_idx;
    logic                w_misalign;
    logic                w_oor;
    logic                w_is_wr;
    logic                w_acc;
    logic                w_wr_ok;
    logic                w_rd;
    logic                w_bad;
    logic                w_clr;
    logic [c_ptr_w-1:0]  w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [c_nbytes-1:0] w_be;

    logic [DATA_W-1:0]   r_mem [0:MEM_DEPTH-1];
    logic                r_v1;
    logic                r_err;
    logic [DATA_W-1:0]   r_d1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_idx = addrb[ADDR_W-1:c_ofs];
    assign w_oor = !(c_cmp_w'(w_idx) < c_depth);

    generate
        if (c_ofs > 0) begin : g_ofs
            assign w_misalign = |addrb[c_ofs-1:0];
        end else begin : g_no_ofs
            assign w_misalign = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reset / clear / idle state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clkb) begin
        if (!rstb_n) begin
            r_state <= c_st_rst;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_st_rst: begin
                w_ptr_nxt   = '0;
                w_state_nxt = (CLEAR_ON_RESET != 0) ? c_st_clear : c_st_idle;
            end
            c_st_clear: begin
                w_ptr_nxt = r_ptr + c_ptr_w'(1);
                if (r_ptr == c_last) begin
                    w_state_nxt = c_st_idle;
                    w_ptr_nxt   = '0;
                end
            end
            c_st_idle: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_rst;
            end
        endcase
    end

    assign rstb_busy = (r_state != c_st_idle);

    // ------------------------------------------------------------------
    // Access qualification; memory is never touched while reset is held
    // ------------------------------------------------------------------
    assign w_is_wr = |web;
    assign w_acc   = rstb_n & enb & (r_state == c_st_idle);
    assign w_wr_ok = w_acc & w_is_wr & ~w_misalign & ~w_oor;
    assign w_rd    = w_acc & ~w_is_wr;
    assign w_bad   = w_acc & ((w_is_wr & (w_misalign | w_oor)) | (~w_is_wr & w_oor));
    assign w_clr   = rstb_n & (r_state == c_st_clear);

    assign w_addr  = w_clr ? r_ptr : w_idx[c_ptr_w-1:0];
    assign w_wdata = w_clr ? INIT_VALUE : dinb;
    assign w_be    = w_clr ? '1 : (w_wr_ok ? web : '0);

    always_ff @(posedge clkb) begin
        for (int b = 0; b < c_nbytes; b++) begin
            if (w_be[b]) begin
                r_mem[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // First read stage; data only moves on a read so doutb holds otherwise
    always_ff @(posedge clkb) begin
        if (!rstb_n) begin
            r_v1  <= 1'b0;
            r_err <= 1'b0;
            r_d1  <= '0;
        end else begin
            r_v1  <= w_rd;
            r_err <= w_bad;
            if (w_rd) begin
                r_d1 <= w_oor ? '0 : r_mem[w_addr];
            end
        end
    end

    assign err = r_err;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              r_v2;
            logic [DATA_W-1:0] r_d2;

            always_ff @(posedge clkb) begin
                if (!rstb_n) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign rvalid = r_v2;
            assign doutb  = r_d2;
        end else begin : g_lat1
            assign rvalid = r_v1;
            assign doutb  = r_d1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bram_port_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_v2
// Brief    : Scoreboard bench driving latency-1 and latency-2 instances of
//            bram_port_v2 with identical stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_v2;

    localparam int DEPTH = 1024;

    logic        tb_clk = 1'b0;
    logic        rstb_n;
    logic        enb;
    logic [3:0]  web;
    logic [31:0] addrb;
    logic [31:0] dinb;
    logic [31:0] doutb1, doutb2;
    logic        rvalid1, rvalid2, err1, err2, busy1, busy2;

    always #5 tb_clk = ~tb_clk;

    bram_port_v2 #(.DATA_W(32), .MEM_DEPTH(DEPTH), .ADDR_W(32), .READ_LATENCY(1),
                   .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)) u_dut1 (
        .clkb(tb_clk), .rstb_n(rstb_n), .enb(enb), .web(web), .addrb(addrb),
        .dinb(dinb), .doutb(doutb1), .rvalid(rvalid1), .err(err1), .rstb_busy(busy1));

    bram_port_v2 #(.DATA_W(32), .MEM_DEPTH(DEPTH), .ADDR_W(32), .READ_LATENCY(2),
                   .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)) u_dut2 (
        .clkb(tb_clk), .rstb_n(rstb_n), .enb(enb), .web(web), .addrb(addrb),
        .dinb(dinb), .doutb(doutb2), .rvalid(rvalid2), .err(err2), .rstb_busy(busy2));

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        q [2][$];
    bit          err_exp [int];
    logic [31:0] model [0:DEPTH-1];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    bit          bench_busy = 1'b1;

    always @(posedge tb_clk) cyc <= cyc + 1;

    // Read results and error pulses are checked every cycle against the queues
    always @(negedge tb_clk) begin
        logic [1:0]  rv;
        logic [1:0]  ev;
        logic [31:0] dv [2];
        logic        e_err;
        exp_t        e;
        if (mon_en) begin
            rv    = {rvalid2, rvalid1};
            ev    = {err2, err1};
            dv[0] = doutb1;
            dv[1] = doutb2;
            e_err = err_exp.exists(cyc) ? 1'b1 : 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (rv[d] === 1'b1) begin
                    total++;
                    if (q[d].size() == 0) begin
                        bad++;
                        $display("FAIL rd_unexpected dut%0d: got rvalid=1 data=%h at cycle %0d, expected no read result",
                                 d + 1, dv[d], cyc);
                    end else begin
                        e = q[d].pop_front();
                        if (e.due != cyc || dv[d] !== e.data) begin
                            bad++;
                            $display("FAIL rd_data dut%0d: got data=%h at cycle %0d, expected data=%h at cycle %0d",
                                     d + 1, dv[d], cyc, e.data, e.due);
                        end
                    end
                end else if (q[d].size() != 0 && q[d][0].due <= cyc) begin
                    total++;
                    bad++;
                    e = q[d].pop_front();
                    $display("FAIL rd_missing dut%0d: got rvalid=%b at cycle %0d, expected data=%h",
                             d + 1, rv[d], cyc, e.data);
                end
                total++;
                if (ev[d] !== e_err) begin
                    bad++;
                    $display("FAIL err_pulse dut%0d: got err=%b at cycle %0d, expected %b",
                             d + 1, ev[d], cyc, e_err);
                end
            end
        end
    end

    task automatic model_fill(input logic [31:0] v);
        for (int i = 0; i < DEPTH; i++) model[i] = v;
    endtask

    task automatic do_read(input logic [31:0] a);
        int          k;
        int          idx;
        logic [31:0] d;
        @(negedge tb_clk);
        enb   = 1'b1;
        web   = 4'b0000;
        addrb = a;
        dinb  = $urandom;
        k     = cyc + 1;
        if (!bench_busy) begin
            idx = int'(a >> 2);
            d   = (idx < DEPTH) ? model[idx] : 32'h0;
            q[0].push_back(exp_t'{k, d});
            q[1].push_back(exp_t'{k + 1, d});
            if (idx >= DEPTH) err_exp[k] = 1'b1;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int k;
        int idx;
        @(negedge tb_clk);
        enb   = 1'b1;
        web   = be;
        addrb = a;
        dinb  = d;
        k     = cyc + 1;
        if (!bench_busy) begin
            idx = int'(a >> 2);
            if (a[1:0] != 2'b00 || idx >= DEPTH) begin
                err_exp[k] = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic do_idle(input int n);
        @(negedge tb_clk);
        enb = 1'b0;
        web = 4'b0000;
        repeat (n - 1) @(negedge tb_clk);
    endtask

    // Releases reset and counts busy cycles; optionally pokes accesses mid-sweep
    task automatic release_and_count(input bit inject, output int n1, output int n2);
        n1 = 0;
        n2 = 0;
        @(negedge tb_clk);
        rstb_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge tb_clk);
            if (busy1 === 1'b1) n1++;
            if (busy2 === 1'b1) n2++;
            if (busy1 === 1'b0 && busy2 === 1'b0) break;
            if (inject && n1 >= 600 && n1 <= 604) begin
                enb = 1'b1;
                case (n1)
                    600:     begin web = 4'hF; addrb = 32'h0;    dinb = 32'hFFFF_FFFF; end
                    601:     begin web = 4'h0; addrb = 32'h0;    end
                    602:     begin web = 4'hF; addrb = 32'h1000; dinb = 32'h1234_5678; end
                    603:     begin web = 4'hF; addrb = 32'h6;    end
                    default: begin web = 4'h0; addrb = 32'h1000; end
                endcase
            end else begin
                enb = 1'b0;
            end
        end
        enb        = 1'b0;
        web        = 4'h0;
        bench_busy = 1'b0;
        model_fill(32'h0);
    endtask

    task automatic test_reset();
        int n1, n2;
        enb        = 1'b0;
        web        = 4'h0;
        addrb      = 32'h0;
        dinb       = 32'h0;
        rstb_n     = 1'b0;
        bench_busy = 1'b1;
        repeat (10) @(negedge tb_clk);
        mon_en = 1'b1;
        total++;
        if ({busy1, rvalid1, err1, doutb1} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_state dut1: got busy=%b rvalid=%b err=%b dout=%h, expected 1 0 0 00000000",
                     busy1, rvalid1, err1, doutb1);
        end
        total++;
        if ({busy2, rvalid2, err2, doutb2} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_state dut2: got busy=%b rvalid=%b err=%b dout=%h, expected 1 0 0 00000000",
                     busy2, rvalid2, err2, doutb2);
        end
        release_and_count(1'b0, n1, n2);
        total++;
        if (n1 != DEPTH) begin
            bad++;
            $display("FAIL busy_len dut1: got %0d cycles, expected %0d", n1, DEPTH);
        end
        total++;
        if (n2 != DEPTH) begin
            bad++;
            $display("FAIL busy_len dut2: got %0d cycles, expected %0d", n2, DEPTH);
        end
        do_read(32'h0);
        do_read(32'hFFC);
        do_idle(3);
    endtask

    task automatic test_byte_enables();
        do_write(32'h0, 32'hDEAD_BEEF, 4'b1011);
        do_write(32'h4, 32'h1234_5678, 4'b1111);
        do_read(32'h0);
        do_read(32'h4);
        do_idle(4);
        total++;
        if (doutb1 !== 32'h1234_5678 || doutb2 !== 32'h1234_5678) begin
            bad++;
            $display("FAIL byte_en_hold: got %h/%h, expected 12345678", doutb1, doutb2);
        end
    endtask

    task automatic test_misaligned();
        do_read(32'h3);
        do_write(32'h8, 32'hCAFE_BABE, 4'hF);
        do_read(32'hA);
        do_write(32'h6, 32'hFFFF_FFFF, 4'hF);
        do_read(32'h4);
        do_idle(4);
        total++;
        if (doutb1 !== 32'h1234_5678 || doutb2 !== 32'h1234_5678) begin
            bad++;
            $display("FAIL misaligned_write_dropped: got %h/%h, expected 12345678", doutb1, doutb2);
        end
    endtask

    task automatic test_out_of_range();
        do_write(32'h1000, 32'hAABB_CCDD, 4'hF);
        do_read(32'h1000);
        do_read(32'h0);
        do_read(32'h1000);
        do_idle(4);
        total++;
        if (doutb1 !== 32'h0 || doutb2 !== 32'h0) begin
            bad++;
            $display("FAIL oor_read_zero: got %h/%h, expected 00000000", doutb1, doutb2);
        end
    endtask

    task automatic test_back_to_back();
        do_read(32'h0);
        do_read(32'h4);
        do_read(32'h8);
        do_write(32'hC, 32'h0BAD_F00D, 4'hF);
        do_read(32'hC);
        do_idle(5);
        total++;
        if (doutb2 !== 32'h0BAD_F00D || rvalid2 !== 1'b0) begin
            bad++;
            $display("FAIL dout_hold dut2: got dout=%h rvalid=%b, expected 0badf00d 0", doutb2, rvalid2);
        end
    endtask

    task automatic test_mid_reset();
        int n1, n2;
        do_write(32'h0, 32'h1122_3344, 4'hF);
        do_read(32'h0);
        do_idle(3);
        @(negedge tb_clk);
        rstb_n     = 1'b0;
        bench_busy = 1'b1;
        repeat (5) @(negedge tb_clk);
        rstb_n = 1'b1;
        repeat (500) @(negedge tb_clk);
        rstb_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            total++;
            if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
                bad++;
                $display("FAIL busy_in_reset: got %b/%b, expected 1", busy1, busy2);
            end
        end
        release_and_count(1'b1, n1, n2);
        total++;
        if (n1 != DEPTH || n2 != DEPTH) begin
            bad++;
            $display("FAIL busy_len_restart: got %0d/%0d cycles, expected %0d", n1, n2, DEPTH);
        end
        do_read(32'h0);
        do_read(32'h4);
        do_read(32'hFFC);
        do_idle(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no end of test by 1 ms, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_byte_enables();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_mid_reset();
        do_idle(4);
        total++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            bad++;
            $display("FAIL pending_reads: got %0d/%0d outstanding, expected 0", q[0].size(), q[1].size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
